// File: rtl/div_sel_pkg.sv
// Shared definitions for div_select_seq: state encoding and counter sizing.
package div_sel_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DIV_AB = 3'd1;
  localparam logic [2:0] ST_CHECK  = 3'd2;
  localparam logic [2:0] ST_DIV_CD = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    DIV_AB = ST_DIV_AB,
    CHECK  = ST_CHECK,
    DIV_CD = ST_DIV_CD,
    DONE   = ST_DONE
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/seq_div.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, MSB first.
// The first iteration is performed in the start cycle; done is a level that holds until the next start.
module seq_div
  import div_sel_pkg::*;
#(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] dividend,
  input  logic [DATAWIDTH-1:0] divisor,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem
);

  localparam int CW = clog2(DATAWIDTH + 1);

  logic [DATAWIDTH-1:0] rem_q, rem_d;
  logic [DATAWIDTH-1:0] quot_q, quot_d;
  logic [DATAWIDTH-1:0] dvsr_q, dvsr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [DATAWIDTH-1:0] acc, qsh, dv;
  logic [DATAWIDTH:0]   shifted, diff;

  // A borrow out of the trial subtract means the divisor did not fit: keep the shifted value.
  always_comb begin
    acc     = start ? '0 : rem_q;
    qsh     = start ? dividend : quot_q;
    dv      = start ? divisor : dvsr_q;
    shifted = {acc, qsh[DATAWIDTH-1]};
    diff    = shifted - {1'b0, dv};

    rem_d  = rem_q;
    quot_d = quot_q;
    dvsr_d = dvsr_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;

    if (start || busy_q) begin
      rem_d  = diff[DATAWIDTH] ? shifted[DATAWIDTH-1:0] : diff[DATAWIDTH-1:0];
      quot_d = {qsh[DATAWIDTH-2:0], ~diff[DATAWIDTH]};
      dvsr_d = dv;
    end

    if (start) begin
      cnt_d  = CW'(1);
      busy_d = 1'b1;
      done_d = 1'b0;
    end else if (busy_q) begin
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == CW'(DATAWIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvsr_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/div_select_seq.sv
// z = ((a mod b) == zero) ? c/d : a/b using one shared sequential divider behind valid/ready handshakes.
// Optional divide-by-zero flag output dz is built when DIVZERO_FLAG_EN is defined.
module div_select_seq
  import div_sel_pkg::*;
#(
  parameter int DATAWIDTH = 64
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  input  logic [DATAWIDTH-1:0] c,
  input  logic [DATAWIDTH-1:0] d,
  input  logic [DATAWIDTH-1:0] zero,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] z
`ifdef DIVZERO_FLAG_EN
  ,
  output logic                 dz
`endif
);

  state_t               state_q, state_d;
  logic [DATAWIDTH-1:0] c_q, c_d, d_q, d_d, zero_q, zero_d;
  logic [DATAWIDTH-1:0] z_q, z_d;
  logic                 out_valid_q, out_valid_d;
`ifdef DIVZERO_FLAG_EN
  logic [DATAWIDTH-1:0] b_q, b_d;
  logic                 dz_q, dz_d;
`endif

  logic                 div_start, div_busy, div_done;
  logic [DATAWIDTH-1:0] div_dividend, div_divisor, div_quot, div_rem;

  seq_div #(.DATAWIDTH(DATAWIDTH)) u_div (
    .Clk      (Clk),
    .Rst      (Rst),
    .start    (div_start),
    .dividend (div_dividend),
    .divisor  (div_divisor),
    .busy     (div_busy),
    .done     (div_done),
    .quot     (div_quot),
    .rem      (div_rem)
  );

  // a/b is fed straight from the ports so the divider starts on the handshake edge.
  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    d_d          = d_q;
    zero_d       = zero_q;
    z_d          = z_q;
    out_valid_d  = out_valid_q;
    div_start    = 1'b0;
    div_dividend = c_q;
    div_divisor  = d_q;
`ifdef DIVZERO_FLAG_EN
    b_d  = b_q;
    dz_d = dz_q;
`endif
    case (state_q)
      IDLE: begin
        div_dividend = a;
        div_divisor  = b;
        if (in_valid) begin
          c_d       = c;
          d_d       = d;
          zero_d    = zero;
`ifdef DIVZERO_FLAG_EN
          b_d       = b;
`endif
          div_start = 1'b1;
          state_d   = DIV_AB;
        end
      end
      DIV_AB: if (div_done && !div_busy) state_d = CHECK;
      CHECK: begin
        if (div_rem == zero_q) begin
          div_start = 1'b1;
          state_d   = DIV_CD;
        end else begin
          z_d         = div_quot;
          out_valid_d = 1'b1;
`ifdef DIVZERO_FLAG_EN
          dz_d        = (b_q == '0);
`endif
          state_d     = DONE;
        end
      end
      DIV_CD: begin
        if (div_done && !div_busy) begin
          z_d         = div_quot;
          out_valid_d = 1'b1;
`ifdef DIVZERO_FLAG_EN
          dz_d        = (d_q == '0);
`endif
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= IDLE;
      c_q         <= '0;
      d_q         <= '0;
      zero_q      <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
`ifdef DIVZERO_FLAG_EN
      b_q         <= '0;
      dz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      d_q         <= d_d;
      zero_q      <= zero_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
`ifdef DIVZERO_FLAG_EN
      b_q         <= b_d;
      dz_q        <= dz_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign z         = z_q;
`ifdef DIVZERO_FLAG_EN
  assign dz        = dz_q;
`endif

endmodule

// File: tb/tb_div_select_seq.sv
// Self-checking bench for div_select_seq at DATAWIDTH = 8 against an arithmetic reference model.
// Build with DIVZERO_FLAG_EN defined to also check the dz flag.
module tb_div_select_seq;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, c, d, zero;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
`ifdef DIVZERO_FLAG_EN
  logic         dz;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] a, b, c, d, zero;
    int           hold;
  } vec_t;

  always #5 Clk = ~Clk;

  div_select_seq #(.DATAWIDTH(W)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .zero      (zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z)
`ifdef DIVZERO_FLAG_EN
    ,
    .dz        (dz)
`endif
  );

  // Reference arithmetic: division by zero yields all ones with the dividend as remainder.
  function automatic logic [W-1:0] ref_quot(input logic [W-1:0] x, input logic [W-1:0] y);
    return (y == 0) ? {W{1'b1}} : x / y;
  endfunction

  function automatic logic [W-1:0] ref_rem(input logic [W-1:0] x, input logic [W-1:0] y);
    return (y == 0) ? x : x % y;
  endfunction

  function automatic logic ref_match(input vec_t v);
    return ref_rem(v.a, v.b) == v.zero;
  endfunction

  function automatic logic [W-1:0] ref_z(input vec_t v);
    return ref_match(v) ? ref_quot(v.c, v.d) : ref_quot(v.a, v.b);
  endfunction

  function automatic logic ref_dz(input vec_t v);
    return ref_match(v) ? (v.d == 0) : (v.b == 0);
  endfunction

  function automatic int ref_lat(input vec_t v);
    return ref_match(v) ? 2 * W + 2 : W + 2;
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after the handshake.
  task automatic send(input vec_t v);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 64) begin
      @(negedge Clk);
      n++;
    end
    a = v.a; b = v.b; c = v.c; d = v.d; zero = v.zero;
    in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom); zero = W'($urandom);
  endtask

  // Called in cycle 1 after the handshake; lat is the cycle out_valid is first seen, -1 on timeout.
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(negedge Clk);
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; c = '0; d = '0; zero = '0;
    repeat (2) @(negedge Clk);
    n_checks++;
    if (z !== '0) $display("[TB] FAIL reset_z: got %0d expected 0", z); else n_pass++;
    n_checks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
`ifdef DIVZERO_FLAG_EN
    n_checks++;
    if (dz !== 1'b0) $display("[TB] FAIL reset_dz: got %b expected 0", dz); else n_pass++;
`endif
    Rst = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_transactions();
    vec_t q[$];
    vec_t v;
    int   lat;
    q.push_back('{a: 8'd17, b: 8'd5, c: 8'd100, d: 8'd7, zero: 8'd0, hold: 0});
    q.push_back('{a: 8'd17, b: 8'd5, c: 8'd100, d: 8'd7, zero: 8'd2, hold: 0});
    q.push_back('{a: 8'd9,  b: 8'd0, c: 8'd0,   d: 8'd0, zero: 8'd9, hold: 1});
    for (int i = 0; i < 30; i++) begin
      v.a    = W'($urandom);
      v.b    = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 40));
      v.c    = W'($urandom);
      v.d    = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 255));
      v.zero = ($urandom_range(0, 1) == 0) ? ref_rem(v.a, v.b) : W'($urandom);
      v.hold = $urandom_range(0, 3);
      q.push_back(v);
    end
    foreach (q[k]) begin
      v = q[k];
      out_ready = 1'b0;
      send(v);
      wait_out(lat);
      n_checks++;
      if (lat != ref_lat(v))
        $display("[TB] FAIL txn%0d_latency: got %0d expected %0d", k, lat, ref_lat(v));
      else n_pass++;
      n_checks++;
      if (z !== ref_z(v))
        $display("[TB] FAIL txn%0d_z: got %0d expected %0d (a=%0d b=%0d c=%0d d=%0d zero=%0d)",
                 k, z, ref_z(v), v.a, v.b, v.c, v.d, v.zero);
      else n_pass++;
`ifdef DIVZERO_FLAG_EN
      n_checks++;
      if (dz !== ref_dz(v)) $display("[TB] FAIL txn%0d_dz: got %b expected %b", k, dz, ref_dz(v));
      else n_pass++;
`endif
      n_checks++;
      if (in_ready !== 1'b0) $display("[TB] FAIL txn%0d_in_ready_done: got %b expected 0", k, in_ready);
      else n_pass++;
      repeat (v.hold) @(negedge Clk);
      if (v.hold > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || z !== ref_z(v))
          $display("[TB] FAIL txn%0d_hold: got valid=%b z=%0d expected valid=1 z=%0d", k, out_valid, z, ref_z(v));
        else n_pass++;
      end
      out_ready = 1'b1;
      @(negedge Clk);
      out_ready = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("[TB] FAIL txn%0d_release: got valid=%b ready=%b expected valid=0 ready=1", k, out_valid, in_ready);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    vec_t v;
    int   lat;
    v = '{a: 8'd17, b: 8'd5, c: 8'd100, d: 8'd7, zero: 8'd2, hold: 5};
    out_ready = 1'b0;
    send(v);
    wait_out(lat);
    n_checks++;
    if (lat != 2 * W + 2) $display("[TB] FAIL bp_latency: got %0d expected %0d", lat, 2 * W + 2); else n_pass++;
    // Offer a competing operand set while stalled; it must not be taken.
    a = 8'd50; b = 8'd3; c = 8'd1; d = 8'd1; zero = 8'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || z !== 8'd14 || in_ready !== 1'b0)
        $display("[TB] FAIL bp_stall%0d: got valid=%b z=%0d ready=%b expected valid=1 z=14 ready=0",
                 i, out_valid, z, in_ready);
      else n_pass++;
      @(negedge Clk);
    end
    out_ready = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready);
    else n_pass++;
    @(negedge Clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || z !== 8'd14)
      $display("[TB] FAIL bp_single_transfer: got valid=%b ready=%b z=%0d expected valid=0 ready=1 z=14",
               out_valid, in_ready, z);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    vec_t v;
    int   lat;
    v = '{a: 8'd200, b: 8'd3, c: 8'd40, d: 8'd9, zero: 8'd0, hold: 0};
    out_ready = 1'b0;
    send(v);
    repeat (3) @(negedge Clk);
    #1 Rst = 1'b0;
    #1;
    n_checks++;
    if (z !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL midreset_state: got z=%0d valid=%b ready=%b expected z=0 valid=0 ready=1",
               z, out_valid, in_ready);
    else n_pass++;
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    v = '{a: 8'd255, b: 8'd16, c: W'($urandom), d: W'($urandom), zero: 8'd1, hold: 0};
    send(v);
    wait_out(lat);
    n_checks++;
    if (z !== 8'd15 || lat != W + 2)
      $display("[TB] FAIL midreset_fresh: got z=%0d lat=%0d expected z=15 lat=%0d", z, lat, W + 2);
    else n_pass++;
`ifdef DIVZERO_FLAG_EN
    n_checks++;
    if (dz !== 1'b0) $display("[TB] FAIL midreset_dz: got %b expected 0", dz); else n_pass++;
`endif
    out_ready = 1'b1;
    @(negedge Clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    int lat;
    out_ready = 1'b1;
    a = 8'd17; b = 8'd5; c = 8'd100; d = 8'd7; zero = 8'd0;
    in_valid = 1'b1;
    n_checks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL b2b_first_ready: got %b expected 1", in_ready); else n_pass++;
    cyc = 0;
    do begin
      @(negedge Clk);
      cyc++;
    end while (out_valid !== 1'b1 && cyc < 200);
    n_checks++;
    if (cyc != W + 2 || z !== 8'd3 || in_ready !== 1'b0)
      $display("[TB] FAIL b2b_first_result: got cyc=%0d z=%0d ready=%b expected cyc=%0d z=3 ready=0",
               cyc, z, in_ready, W + 2);
    else n_pass++;
    zero = 8'd2;
    @(negedge Clk);
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("[TB] FAIL b2b_reaccept_cycle: got ready=%b valid=%b expected ready=1 valid=0", in_ready, out_valid);
    else n_pass++;
    @(negedge Clk);
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL b2b_second_accepted: got ready=%b expected 0", in_ready); else n_pass++;
    wait_out(lat);
    n_checks++;
    if (lat != 2 * W + 2 || z !== 8'd14)
      $display("[TB] FAIL b2b_second_result: got lat=%0d z=%0d expected lat=%0d z=14", lat, z, 2 * W + 2);
    else n_pass++;
    @(negedge Clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_transactions();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
